// File: rtl/sclk_period_monitor_pkg.sv
// ---------------------------------------------------------------------------
// sclk_mon_pkg
// Shared types and constants for the sclk period monitor and its
// synchronizer sub-block.
//   sclk_mon_state_t : lock FSM states (IDLE, ACQUIRE, LOCKED, LOST)
//   SYNC_STAGES      : number of metastability flops ahead of edge detection
// ---------------------------------------------------------------------------
package sclk_mon_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } sclk_mon_state_t;

endpackage

// File: rtl/sclk_period_monitor_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk domain through a STAGES-deep
// flop chain, then compares the synchronized level against one more delay
// flop so that both rising and falling transitions produce a one-cycle
// pulse. Usable for any slow asynchronous input, not only sclk.
// Ports:
//   clk      in  : sampling clock
//   reset    in  : asynchronous active-low reset, clears every flop
//   async_in in  : asynchronous input level
//   edge_det out : one-cycle pulse on either transition of the synced level
//                  ("edge" itself is a reserved word)
//   level    out : synchronized level
// ---------------------------------------------------------------------------
module sync_edge_detect
    import sclk_mon_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_det,
    output logic level
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_edge_detect: STAGES must be at least 2");
    end

    // Shift the raw input through the synchronizer; the extra delay flop
    // holds the previous synchronized level for edge comparison.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level    = sync_q[STAGES-1];
    assign edge_det = sync_q[STAGES-1] ^ dly_q;

endmodule

// File: rtl/sclk_period_monitor.sv
// ---------------------------------------------------------------------------
// sclk_period_monitor
// Measures the spacing of sclk edges (both polarities) in clk cycles and
// runs a lock FSM against an expected half-period +/- tolerance.
// Optional statistics outputs are built when SCLK_MON_STATS_EN is defined.
// Ports:
//   clk          in  : fast system clock
//   reset        in  : asynchronous active-low reset
//   sclk_in      in  : divided clock under test, asynchronous to clk
//   half_period  out : last measured edge-to-edge interval (saturating)
//   period_valid out : one-cycle pulse when half_period updates
//   locked       out : FSM is in LOCKED
//   lost         out : FSM is in LOST
//   timeout      out : one-cycle pulse when an interval overruns
//                      EXPECTED_HALF+TOLERANCE cycles without an edge
//   min_period   out : (SCLK_MON_STATS_EN) smallest judged capture
//   max_period   out : (SCLK_MON_STATS_EN) largest judged capture
//   err_count    out : (SCLK_MON_STATS_EN) bad edges + timeouts, saturating
// ---------------------------------------------------------------------------
module sclk_period_monitor
    import sclk_mon_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int EXPECTED_HALF = 5000000,
    parameter int TOLERANCE     = 4,
    parameter int LOCK_COUNT    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic             timeout
`ifdef SCLK_MON_STATS_EN
    ,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic [15:0]      err_count
`endif
);

    localparam logic [CNT_W:0]   EXP_W      = (CNT_W+1)'(EXPECTED_HALF);
    localparam logic [CNT_W:0]   TOL_W      = (CNT_W+1)'(TOLERANCE);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(EXPECTED_HALF + TOLERANCE);
    localparam logic [3:0]       LOCK_N     = 4'(LOCK_COUNT);

    if (longint'(EXPECTED_HALF) + longint'(TOLERANCE) > (longint'(1) << CNT_W) - 1)
    begin : g_bad_threshold
        $error("sclk_period_monitor: EXPECTED_HALF+TOLERANCE does not fit in CNT_W bits");
    end

    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
        $error("sclk_period_monitor: LOCK_COUNT must be in 1..15");
    end

    logic             edge_det;
    logic             sclk_level_unused;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic [CNT_W:0]   cap_w;
    logic [CNT_W:0]   diff_w;
    logic             good;
    logic             timeout_hit;
    logic             timeout_done_q;
    sclk_mon_state_t  state_q, state_d;
    logic [3:0]       good_q, good_d;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (sclk_in),
        .edge_det (edge_det),
        .level    (sclk_level_unused)
    );

    // Capture value is cnt+1, clamped so a stalled sclk reports all-ones
    // rather than wrapping. The tolerance test runs one bit wider so the
    // absolute difference never underflows.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        cnt_sat = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
        cap_w   = {1'b0, cnt_sat};
        diff_w  = (cap_w >= EXP_W) ? (cap_w - EXP_W) : (EXP_W - cap_w);
        good    = (diff_w <= TOL_W);
    end

    // The done flag keeps the timeout to a single pulse per interval even
    // when the threshold equals the saturation value and cnt parks there.
    assign timeout_hit = !edge_det && !timeout_done_q && (cnt_q == TIMEOUT_AT);

    // Interval counter, capture register and the two single-cycle strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q          <= '0;
            half_period    <= '0;
            period_valid   <= 1'b0;
            timeout        <= 1'b0;
            timeout_done_q <= 1'b0;
        end else begin
            timeout <= timeout_hit;
            if (edge_det) begin
                cnt_q          <= '0;
                half_period    <= cnt_sat;
                period_valid   <= 1'b1;
                timeout_done_q <= 1'b0;
            end else begin
                cnt_q        <= cnt_sat;
                period_valid <= 1'b0;
                if (timeout_hit) begin
                    timeout_done_q <= 1'b1;
                end
            end
        end
    end

    // Lock FSM state register and consecutive-good counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Intervals seen in IDLE and LOST started at an unknown time, so those
    // edges only move the FSM back into ACQUIRE and are not judged.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            IDLE: begin
                if (edge_det) begin
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (edge_det && good) begin
                    if (good_q + 4'd1 == LOCK_N) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end else if (edge_det || timeout_hit) begin
                    good_d = '0;
                end
            end
            LOCKED: begin
                if ((edge_det && !good) || timeout_hit) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (edge_det) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase
    end

    assign locked = (state_q == LOCKED);
    assign lost   = (state_q == LOST);

`ifdef SCLK_MON_STATS_EN
    logic judged;
    logic bad_event;

    assign judged    = (state_q == ACQUIRE) || (state_q == LOCKED);
    assign bad_event = judged && ((edge_det && !good) || timeout_hit);

    // Running min/max over judged captures and a saturating error tally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_period <= {CNT_W{1'b1}};
            max_period <= '0;
            err_count  <= '0;
        end else begin
            if (edge_det && judged) begin
                if (cnt_sat < min_period) begin
                    min_period <= cnt_sat;
                end
                if (cnt_sat > max_period) begin
                    max_period <= cnt_sat;
                end
            end
            if (bad_event && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/sclk_period_monitor.md
Name: sclk_period_monitor

Overview:
Receive-side checker for a divided clock produced by the clock divider. It samples the slow `sclk` in the fast `clk` domain, measures the interval between consecutive `sclk` edges in `clk` cycles, and declares lock or loss against an expected half-period. Instantiated next to any consumer of `sclk` so that downstream logic can gate on `locked` and alarm on `lost`.

Parameters:
- CNT_W, 32, width of the interval counter and `half_period`.
- EXPECTED_HALF, 5000000, nominal `clk` cycles between successive `sclk` edges (rising to falling, or falling to rising).
- TOLERANCE, 4, allowed deviation; an interval is good iff |interval − EXPECTED_HALF| ≤ TOLERANCE.
- LOCK_COUNT, 4, number of consecutive good intervals required to enter LOCKED; range 1–15.

Ports:
- clk, input, 1, fast system clock.
- reset, input, 1, asynchronous active-low reset.
- sclk_in, input, 1, divided clock under test; asynchronous to `clk`.
- half_period, output, CNT_W, last measured interval.
- period_valid, output, 1, one-cycle pulse when `half_period` updates.
- locked, output, 1, high while the FSM is in LOCKED.
- lost, output, 1, high while the FSM is in LOST.
- timeout, output, 1, one-cycle pulse when no edge arrives within EXPECTED_HALF+TOLERANCE cycles.

Behaviour:
- Reset is decided: reset is asynchronous, active-low; clock is clk.
- While `reset`=0, all flops clear:
  - `half_period`=0, `period_valid`=0, `locked`=0, `lost`=0, `timeout`=0.
  - Synchronizer=0, counter=0, good count=0, FSM=IDLE.
  - Asserting reset mid-operation aborts any measurement immediately.
- Synchronization: 2-flop synchronizer on `sclk_in`, then a delay flop for edge detection. `edge` = sync2 XOR sync3, so both edges count. Latency from a `sclk_in` transition to `edge` is 3 `clk` cycles. The bare `sclk_in` is never used in logic.
- Interval counter `cnt`:
  - On `edge`: capture `half_period` ← `cnt`+1 (saturating at 2^CNT_W−1), then set `cnt` ← 0 and pulse `period_valid`.
  - Otherwise: `cnt` ← `cnt`+1, saturating at all-ones.
  - Edges every N cycles therefore report N.
- Timeout: `timeout` pulses for exactly one cycle when no `edge` occurs and `cnt`+1 == EXPECTED_HALF+TOLERANCE+1. It fires once per interval and does not repeat while `cnt` keeps rising or saturates. If `edge` and the threshold coincide, `edge` wins and there is no timeout.
- `period_valid` and `half_period` update in every FSM state, including IDLE. `good` = capture within tolerance.
- FSM states: IDLE, ACQUIRE, LOCKED, LOST.
  - IDLE: first `edge` → ACQUIRE. That interval is discarded because its start is unknown; the good count is not changed.
  - ACQUIRE, good edge: good count +1. When it reaches LOCK_COUNT → LOCKED, and `locked` rises the cycle after that edge.
  - ACQUIRE, bad edge or timeout: good count ← 0, stay in ACQUIRE.
  - LOCKED, bad edge or timeout: → LOST and `locked` falls next cycle. Good edges keep LOCKED.
  - LOST, any edge: → ACQUIRE with good count 0; the interval is discarded. `lost` falls on entry to ACQUIRE.
- Width rules:
  - Tolerance compare is done on CNT_W+1 bits with no underflow.
  - EXPECTED_HALF+TOLERANCE must fit in CNT_W bits; this is checked by an elaboration assertion.

Optional Feature:
Macro SCLK_MON_STATS_EN.
- When defined, the block adds these outputs, all cleared by reset:
  - `min_period` [CNT_W-1:0]: minimum of captures since reset, initialised to all-ones.
  - `max_period` [CNT_W-1:0]: maximum of captures since reset.
  - `err_count` [15:0]: bad edges plus timeouts, saturating at 0xFFFF.
- Captures taken in IDLE and LOST are excluded from the min/max statistics.
- When the macro is undefined, these ports and registers do not exist and core behaviour is identical.

Decomposition:
- Package `sclk_mon_pkg`:
  - State enum `sclk_mon_state_t` (IDLE, ACQUIRE, LOCKED, LOST).
  - Localparam for synchronizer depth (2).
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus delay flop, outputting `edge` and `level`. It is reusable by other clock-domain inputs.

Test Plan (EXPECTED_HALF=10, TOLERANCE=1, LOCK_COUNT=4, CNT_W=8):
1. Reset held, `sclk_in` toggling → all outputs 0. Release, then toggle every 10 cycles → `period_valid` pulses, `half_period`=10; `locked` rises the cycle after the 5th edge (1 discarded + 4 good).
2. Locked, then one interval of 13 → `locked`=0, `lost`=1. Resume period 10 → `lost` clears on the next edge, `locked` returns 4 good edges later.
3. Locked, then `sclk_in` stuck → `timeout` single pulse 12 cycles after the last `edge`, FSM goes to LOST, no further pulses; `cnt` saturates at 255 with no wrap.
4. Intervals of 9 and 11 (boundary) → treated as good and lock is achieved. Intervals of 8 or 12 → good count resets in ACQUIRE.
5. Assert reset mid-interval while LOCKED → `locked`=0 asynchronously, `half_period`=0. After release, the first edge is discarded again.
6. With SCLK_MON_STATS_EN, intervals 10, 9, 11, 13 after IDLE → `min_period`=9, `max_period`=13, `err_count`=1.
